// File: rtl/syssram_pkg.sv
// Shared definitions for the system SRAM port controller: SRAM geometry,
// the response record carried through the response buffer, and a byte-lane
// extraction helper.
package syssram_pkg;

  localparam int SYSSRAM_ADDR_W   = 12;
  localparam int SYSSRAM_DATA_W   = 32;
  localparam int SYSSRAM_LANES    = 4;
  localparam int SYSSRAM_SOURCE_W = 4;

  // One response as it sits in the buffer or is presented on the D channel.
  typedef struct packed {
    logic                        write;
    logic [SYSSRAM_SOURCE_W-1:0] source;
    logic [SYSSRAM_DATA_W-1:0]   data;
  } resp_t;

  // Byte `lane` of a data word (lane 0 = bits [7:0]).
  function automatic logic [7:0] lane_byte(input logic [SYSSRAM_DATA_W-1:0] word,
                                           input int lane);
    return word[8*lane +: 8];
  endfunction

endpackage

// File: rtl/syssram_resp_fifo.sv
// In-order circular response buffer. The head entry is visible
// combinationally on o_head; o_count reports occupancy. The parent never
// pushes when full and never pops when empty.
module syssram_resp_fifo
  import syssram_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push,
  input  resp_t            i_data,
  input  logic             i_pop,
  output resp_t            o_head,
  output logic [CNT_W-1:0] o_count
);

  resp_t            r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage write; contents need no reset because r_count gates visibility.
  always_ff @(posedge clock) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy tracking; push+pop together leaves count unchanged.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= next_ptr(r_wr_ptr);
      end
      if (i_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      if (i_push && !i_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!i_push && i_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/syssram_port_ctrl.sv
// Request/response front end for the byte-lane system SRAM wrapper.
// A-channel requests drive the SRAM directly in the cycle they fire; the
// response (read data or write ack) is either handed straight to the D
// channel or parked in a small in-order buffer. Requests are only accepted
// when a buffer slot is guaranteed for every access still in flight, so the
// SRAM side never has to stall.
// Optional macro SYSSRAM_CTRL_RESP_PIPE_EN adds a register on the SRAM read
// data path (2-cycle response latency, two accesses in flight).
module syssram_port_ctrl
  import syssram_pkg::*;
#(
  parameter int ADDR_W     = SYSSRAM_ADDR_W,
  parameter int SOURCE_W   = SYSSRAM_SOURCE_W,
  parameter int RESP_DEPTH = 2
) (
  input  logic                clock,
  input  logic                reset,
  // A channel (requests)
  input  logic                a_valid,
  output logic                a_ready,
  input  logic                a_write,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [31:0]         a_data,
  input  logic [3:0]          a_mask,
  input  logic [SOURCE_W-1:0] a_source,
  // D channel (responses)
  output logic                d_valid,
  input  logic                d_ready,
  output logic                d_write,
  output logic [31:0]         d_data,
  output logic [SOURCE_W-1:0] d_source,
  // SRAM macro
  output logic [ADDR_W-1:0]   sram_addr,
  output logic                sram_en,
  output logic                sram_wmode,
  output logic [7:0]          sram_wdata_b0,
  output logic [7:0]          sram_wdata_b1,
  output logic [7:0]          sram_wdata_b2,
  output logic [7:0]          sram_wdata_b3,
  output logic [3:0]          sram_wmask,
  input  logic [7:0]          sram_rdata_b0,
  input  logic [7:0]          sram_rdata_b1,
  input  logic [7:0]          sram_rdata_b2,
  input  logic [7:0]          sram_rdata_b3
);

  localparam int              CNT_W   = $clog2(RESP_DEPTH + 1);
  localparam logic [CNT_W:0]  DEPTH_L = (CNT_W + 1)'(RESP_DEPTH);

  logic                w_fire;
  logic [31:0]         w_rdata;
  logic [7:0]          w_wdata_lane [SYSSRAM_LANES];
  logic [CNT_W-1:0]    w_count;
  logic [CNT_W:0]      w_inflight_cnt;
  logic [CNT_W:0]      w_used;
  logic                w_empty;
  logic                w_rsp_valid;
  logic                w_rsp_write;
  logic [SOURCE_W-1:0] w_rsp_source;
  logic [31:0]         w_rsp_rdata;
  resp_t               w_rsp;
  resp_t               w_head;
  logic                w_bypass;
  logic                w_push;
  logic                w_pop;

  // ---------------------------------------------------------------------
  // Credit and SRAM drive. a_ready depends only on registered occupancy
  // (plus reset), never on d_ready.
  // ---------------------------------------------------------------------
  assign w_used  = {1'b0, w_count} + w_inflight_cnt;
  assign a_ready = (w_used < DEPTH_L) && !reset;
  assign w_fire  = a_valid && a_ready;

  assign sram_en    = w_fire;
  assign sram_wmode = w_fire && a_write;
  assign sram_wmask = (w_fire && a_write) ? a_mask : 4'h0;
  assign sram_addr  = reset ? '0 : a_addr;

  for (genvar gi = 0; gi < SYSSRAM_LANES; gi++) begin : g_lane
    assign w_wdata_lane[gi] = reset ? 8'h00 : lane_byte(a_data, gi);
  end

  assign sram_wdata_b0 = w_wdata_lane[0];
  assign sram_wdata_b1 = w_wdata_lane[1];
  assign sram_wdata_b2 = w_wdata_lane[2];
  assign sram_wdata_b3 = w_wdata_lane[3];

  assign w_rdata = {sram_rdata_b3, sram_rdata_b2, sram_rdata_b1, sram_rdata_b0};

`ifdef SYSSRAM_CTRL_RESP_PIPE_EN
  // ---------------------------------------------------------------------
  // Two-stage in-flight tracker: stage 0 is the SRAM access cycle, stage 1
  // lines up with the re-registered read data.
  // ---------------------------------------------------------------------
  logic [1:0]          r_if_valid;
  logic [1:0]          r_if_write;
  logic [SOURCE_W-1:0] r_if_source0;
  logic [SOURCE_W-1:0] r_if_source1;
  logic [31:0]         r_rdata_reg;

  if (RESP_DEPTH < 3) begin : g_depth_chk
    $error("syssram_port_ctrl: RESP_DEPTH must be at least 3 with the response pipe");
  end

  // Shift access metadata through both stages and retime the SRAM read data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_if_valid   <= 2'b00;
      r_if_write   <= 2'b00;
      r_if_source0 <= '0;
      r_if_source1 <= '0;
      r_rdata_reg  <= '0;
    end else begin
      r_if_valid   <= {r_if_valid[0], w_fire};
      r_if_write   <= {r_if_write[0], a_write};
      r_if_source0 <= a_source;
      r_if_source1 <= r_if_source0;
      r_rdata_reg  <= w_rdata;
    end
  end

  assign w_inflight_cnt = (CNT_W + 1)'(r_if_valid[0]) + (CNT_W + 1)'(r_if_valid[1]);
  assign w_rsp_valid    = r_if_valid[1];
  assign w_rsp_write    = r_if_write[1];
  assign w_rsp_source   = r_if_source1;
  assign w_rsp_rdata    = r_rdata_reg;
`else
  // ---------------------------------------------------------------------
  // Single in-flight slot: the response is formed the cycle after the fire
  // directly from the SRAM read data.
  // ---------------------------------------------------------------------
  logic                r_if_valid;
  logic                r_if_write;
  logic [SOURCE_W-1:0] r_if_source;

  // Remember whether an access was issued last cycle and its metadata.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_if_valid  <= 1'b0;
      r_if_write  <= 1'b0;
      r_if_source <= '0;
    end else begin
      r_if_valid <= w_fire;
      if (w_fire) begin
        r_if_write  <= a_write;
        r_if_source <= a_source;
      end
    end
  end

  assign w_inflight_cnt = {{CNT_W{1'b0}}, r_if_valid};
  assign w_rsp_valid    = r_if_valid;
  assign w_rsp_write    = r_if_write;
  assign w_rsp_source   = r_if_source;
  assign w_rsp_rdata    = w_rdata;
`endif

  // Build the response record; write acks carry zero data.
  always_comb begin
    w_rsp        = '0;
    w_rsp.write  = w_rsp_write;
    w_rsp.source = SYSSRAM_SOURCE_W'(w_rsp_source);
    w_rsp.data   = w_rsp_write ? 32'h0 : w_rsp_rdata;
  end

  // ---------------------------------------------------------------------
  // Bypass/buffer steering. A fresh response may only skip the buffer when
  // the buffer is empty, which keeps responses strictly in order.
  // ---------------------------------------------------------------------
  assign w_empty  = (w_count == '0);
  assign w_bypass = w_rsp_valid && w_empty && d_ready;
  assign w_push   = w_rsp_valid && !w_bypass;
  assign w_pop    = !w_empty && d_ready;

  syssram_resp_fifo #(
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_rsp),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign d_valid = !w_empty || w_rsp_valid;

  // D channel shows the buffer head first, else the fresh response, else zeros.
  always_comb begin
    d_write  = 1'b0;
    d_data   = 32'h0;
    d_source = '0;
    if (!w_empty) begin
      d_write  = w_head.write;
      d_data   = w_head.data;
      d_source = SOURCE_W'(w_head.source);
    end else if (w_rsp_valid) begin
      d_write  = w_rsp.write;
      d_data   = w_rsp.data;
      d_source = SOURCE_W'(w_rsp.source);
    end
  end

endmodule

// File: doc/syssram_port_ctrl.md
Name: syssram_port_ctrl

Overview:
- Request/response front end for the system SRAM byte-lane macro wrapper (4096 x 32, 4 byte lanes, 1-cycle synchronous read).
- Accepts valid/ready word requests from the bus adapter and drives the SRAM enable, write mode, address, byte-lane write data and mask.
- Captures read data and returns responses through a small buffer, so the SRAM never stalls and responses survive back-pressure.

Parameters:
- ADDR_W, 12, word-address width (must match SRAM depth).
- SOURCE_W, 4, width of the request tag returned with each response.
- RESP_DEPTH, 2, response buffer entries; must be at least 2, and at least 3 when the optional feature is on.

Ports:
- clock  in  1  single clock; also drives the SRAM clock.
- reset  in  1  asynchronous, active-high.
- a_valid  in  1  request valid.
- a_ready  out  1  request accepted when a_valid & a_ready.
- a_write  in  1  1 = write, 0 = read.
- a_addr  in  ADDR_W  word address.
- a_data  in  32  write data; byte n = bits [8n+7:8n].
- a_mask  in  4  byte write enables.
- a_source  in  SOURCE_W  tag.
- d_valid  out  1  response valid.
- d_ready  in  1  response consumed when d_valid & d_ready.
- d_write  out  1  response is a write ack.
- d_data  out  32  read data; 0 for write acks.
- d_source  out  SOURCE_W  tag echoed from the request.
- sram_addr  out  ADDR_W  SRAM address.
- sram_en  out  1  SRAM enable.
- sram_wmode  out  1  SRAM write mode.
- sram_wdata_b0..b3  out  8 each  byte-lane write data.
- sram_wmask  out  4  {b3,b2,b1,b0} lane enables.
- sram_rdata_b0..b3  in  8 each  byte-lane read data, valid the cycle after a read enable.

Behaviour:
- Reset values: a_ready=0 while reset is asserted. d_valid=0, d_write=0, d_data=0, d_source=0. The buffer is empty and the in-flight flag is clear. All sram_* outputs are 0.
- Fire: fire = a_valid & a_ready.
- SRAM drive (combinational from the A channel):
  - sram_en = fire
  - sram_wmode = fire & a_write
  - sram_addr = a_addr
  - sram_wdata_bN = a_data byte N
  - sram_wmask = a_mask when fire & a_write, else 0
- In-flight register: loads 1 on fire, else 0. Holds write, source and mask-irrelevant metadata for the access.
- Cycle T+1 after a fire at cycle T:
  - Read response data = {sram_rdata_b3..b0}.
  - Write response data = 0.
  - Bypass: if the buffer is empty and d_ready=1, the response is presented on d_* in T+1 and consumed directly, without entering the buffer. A read therefore has 1-cycle latency.
  - Otherwise the response is pushed into the buffer.
- Response buffer:
  - In-order circular FIFO of RESP_DEPTH entries with wrap-around pointers.
  - The head drives d_* when the buffer is non-empty.
  - While the buffer is non-empty, a new response must never bypass the head.
- Credit rule: a_ready = (count + inflight) < RESP_DEPTH, computed from registered state only. There is no combinational path from d_ready to a_ready.
- Simultaneous push and pop: count is unchanged and pointers advance.
- Full buffer: a_ready=0. An in-flight access always has a guaranteed slot.
- Write with a_mask=0: still enables the SRAM with wmask 0 and still produces an ack.
- Reset mid-operation: in-flight and buffered responses are discarded and no d_valid is emitted for them.
- Throughput: 1 request per cycle while d_ready stays high.

Optional Feature:
- Macro: SYSSRAM_CTRL_RESP_PIPE_EN.
- When defined:
  - Read data is registered once more before the bypass/buffer logic (timing relief for the SRAM output path).
  - Response latency becomes 2 cycles.
  - The in-flight tracker becomes a 2-stage shift register, so up to 2 accesses are in flight.
  - The credit rule counts both stages.
  - Full throughput requires RESP_DEPTH >= 3; an elaboration-time assertion checks this.
- When undefined: 1-cycle latency as above.

Decomposition:
- Shared package syssram_pkg:
  - SYSSRAM_ADDR_W = 12, SYSSRAM_DATA_W = 32, SYSSRAM_LANES = 4.
  - Typedef resp_t {write, source, data}.
- One natural sub-module: syssram_resp_fifo, a parameterised in-order FIFO of resp_t with count output.

Test Plan:
1. Write addr 0x010, data 0xDEADBEEF, mask 0xF, then read 0x010 with d_ready=1 -> write ack next cycle with d_data=0; read d_valid one cycle after its fire with d_data=0xDEADBEEF and the matching source.
2. Write 0x020 = 0x11223344 (mask 0xF), then write 0xAABBCCDD with mask 0x5, then read -> d_data=0x11BB33DD; sram_wmask observed as 0x5 during the second write.
3. Hold d_ready=0 and offer back-to-back reads -> exactly RESP_DEPTH accepted, then a_ready=0. Release d_ready -> responses arrive in order with correct tags and no loss.
4. Streaming 16 reads with d_ready=1 -> one fire per cycle; sram_en high 16 consecutive cycles.
5. Assert reset with 2 responses buffered -> d_valid=0 next cycle, a_ready=0 during reset, count=0 after; a subsequent read returns correctly.
6. With SYSSRAM_CTRL_RESP_PIPE_EN and RESP_DEPTH=3 -> read latency 2 cycles; the streaming test still sustains 1 request per cycle.
